// File: rtl/hazard_scoreboard_pkg.sv
package hazard_scoreboard_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic       valid;
    logic [4:0] wreg;
    logic       is_load;
  } slot_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_t;

  // True when the slot will write register r; load_only restricts the match
  // to loads. Register 0 never matches.
  function automatic logic slot_hit(slot_t s, logic [4:0] r, logic load_only);
    return s.valid && (s.is_load || !load_only) && (s.wreg == r) && (r != REG_ZERO);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_muldiv_tracker.sv
module muldiv_tracker
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned DIV_CYCLES = 33,
  parameter int unsigned CNT_W      = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic start,
  input  logic is_div,
  output logic busy,
  output logic done
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  md_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] load_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // BUSY leaves on the cycle the counter would reach 0, so busy spans exactly
  // the configured cycle count including the DONE cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load_val  = is_div ? DIV_LOAD : MUL_LOAD;
    if (flush) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt_nxt   = load_val;
            state_nxt = (load_val == '0) ? DONE : BUSY;
          end
        end
        BUSY: begin
          if (cnt <= CNT_ONE) begin
            cnt_nxt   = '0;
            state_nxt = DONE;
          end else begin
            cnt_nxt = cnt - CNT_ONE;
          end
        end
        DONE: state_nxt = IDLE;
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

endmodule

// File: rtl/hazard_scoreboard.sv
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned DIV_CYCLES = 33,
  parameter int unsigned CNT_W      = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       id_valid,
  input  logic [4:0] id_rreg_a,
  input  logic [4:0] id_rreg_b,
  input  logic       id_use_a,
  input  logic       id_use_b,
  input  logic       id_jmp_reg,
  input  logic       id_RegWrite,
  input  logic [4:0] id_wreg,
  input  logic       id_MemRead,
  input  logic       id_muldiv_start,
  input  logic       id_muldiv_is_div,
  input  logic       id_hilo_access,
  output logic       stall_pc,
  output logic       stall_if_id,
  output logic       bubble_id_ex,
  output logic       muldiv_busy,
  output logic       muldiv_done
);

  slot_t ex_slot, mem_slot, ex_nxt;
  logic  load_use, jr_hz, hilo_hz, stall, md_start;

  always_comb begin
    load_use = (id_use_a & slot_hit(ex_slot, id_rreg_a, 1'b1)) |
               (id_use_b & slot_hit(ex_slot, id_rreg_b, 1'b1));
    // Only EX ALU results reach the PC path, so anything in MEM stalls jr.
    jr_hz    = id_jmp_reg & (slot_hit(ex_slot, id_rreg_a, 1'b1) |
                             slot_hit(mem_slot, id_rreg_a, 1'b0));
    hilo_hz  = muldiv_busy & (id_hilo_access | id_muldiv_start);
    stall    = id_valid & (load_use | jr_hz | hilo_hz) & ~flush;
    md_start = id_valid & id_muldiv_start & ~stall & ~flush;

    ex_nxt.valid   = id_valid & id_RegWrite & (id_wreg != REG_ZERO) & ~stall;
    ex_nxt.wreg    = id_wreg;
    ex_nxt.is_load = id_MemRead;

    stall_pc     = stall;
    stall_if_id  = stall;
    bubble_id_ex = stall;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_slot  <= '0;
      mem_slot <= '0;
    end else if (flush) begin
      ex_slot  <= '0;
      mem_slot <= '0;
    end else begin
      mem_slot <= ex_slot;
      ex_slot  <= ex_nxt;
    end
  end

  muldiv_tracker #(
    .MUL_CYCLES(MUL_CYCLES),
    .DIV_CYCLES(DIV_CYCLES),
    .CNT_W     (CNT_W)
  ) u_muldiv (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .start (md_start),
    .is_div(id_muldiv_is_div),
    .busy  (muldiv_busy),
    .done  (muldiv_done)
  );

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       id_valid;
  logic [4:0] id_rreg_a, id_rreg_b, id_wreg;
  logic       id_use_a, id_use_b, id_jmp_reg, id_RegWrite, id_MemRead;
  logic       id_muldiv_start, id_muldiv_is_div, id_hilo_access;
  logic       stall_pc, stall_if_id, bubble_id_ex, muldiv_busy, muldiv_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .MUL_CYCLES(2),
    .DIV_CYCLES(33),
    .CNT_W     (6)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .id_valid        (id_valid),
    .id_rreg_a       (id_rreg_a),
    .id_rreg_b       (id_rreg_b),
    .id_use_a        (id_use_a),
    .id_use_b        (id_use_b),
    .id_jmp_reg      (id_jmp_reg),
    .id_RegWrite     (id_RegWrite),
    .id_wreg         (id_wreg),
    .id_MemRead      (id_MemRead),
    .id_muldiv_start (id_muldiv_start),
    .id_muldiv_is_div(id_muldiv_is_div),
    .id_hilo_access  (id_hilo_access),
    .stall_pc        (stall_pc),
    .stall_if_id     (stall_if_id),
    .bubble_id_ex    (bubble_id_ex),
    .muldiv_busy     (muldiv_busy),
    .muldiv_done     (muldiv_done)
  );

  typedef struct {
    logic       valid;
    logic [4:0] ra, rb, wr;
    logic       ua, ub, jr, rw, mr, ms, md, hl, fl;
  } in_t;

  typedef struct {
    in_t  i;
    logic st, bz, dn;
  } vec_t;

  typedef struct {
    logic       w;
    logic [4:0] dst;
    logic       ld;
  } rec_t;

  vec_t tbl[$];

  function automatic in_t nop();
    in_t r;
    r = '{default: '0};
    return r;
  endfunction

  function automatic in_t alu(logic [4:0] wr, logic [4:0] ra, logic [4:0] rb);
    in_t r = nop();
    r.valid = 1; r.ra = ra; r.rb = rb; r.ua = 1; r.ub = 1; r.rw = 1; r.wr = wr;
    return r;
  endfunction

  function automatic in_t lw(logic [4:0] wr, logic [4:0] ra);
    in_t r = nop();
    r.valid = 1; r.ra = ra; r.ua = 1; r.rw = 1; r.wr = wr; r.mr = 1;
    return r;
  endfunction

  function automatic in_t jr(logic [4:0] rs);
    in_t r = nop();
    r.valid = 1; r.ra = rs; r.ua = 1; r.jr = 1;
    return r;
  endfunction

  function automatic in_t muldiv(logic is_div);
    in_t r = nop();
    r.valid = 1; r.ra = 5'd1; r.rb = 5'd2; r.ua = 1; r.ub = 1; r.ms = 1; r.md = is_div;
    return r;
  endfunction

  function automatic in_t mfhi(logic [4:0] wr);
    in_t r = nop();
    r.valid = 1; r.hl = 1; r.rw = 1; r.wr = wr;
    return r;
  endfunction

  function automatic in_t mthi(logic [4:0] rs);
    in_t r = nop();
    r.valid = 1; r.ra = rs; r.ua = 1; r.hl = 1;
    return r;
  endfunction

  function automatic in_t with_flush(in_t x);
    in_t r = x;
    r.fl = 1;
    return r;
  endfunction

  task automatic add_vec(in_t x, logic st, logic bz, logic dn);
    vec_t v;
    v.i = x; v.st = st; v.bz = bz; v.dn = dn;
    tbl.push_back(v);
  endtask

  task automatic apply(in_t x);
    id_valid = x.valid; id_rreg_a = x.ra; id_rreg_b = x.rb;
    id_use_a = x.ua; id_use_b = x.ub; id_jmp_reg = x.jr;
    id_RegWrite = x.rw; id_wreg = x.wr; id_MemRead = x.mr;
    id_muldiv_start = x.ms; id_muldiv_is_div = x.md; id_hilo_access = x.hl;
    flush = x.fl;
  endtask

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_outs(string nm, logic st, logic bz, logic dn);
    chk({nm, ".stall_pc"},     int'(stall_pc),     int'(st));
    chk({nm, ".stall_if_id"},  int'(stall_if_id),  int'(st));
    chk({nm, ".bubble_id_ex"}, int'(bubble_id_ex), int'(st));
    chk({nm, ".busy"},         int'(muldiv_busy),  int'(bz));
    chk({nm, ".done"},         int'(muldiv_done),  int'(dn));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    apply(nop());
    #1;
    chk_outs("reset", 1'b0, 1'b0, 1'b0);
    next_cycle();
    rst = 1'b0;
  endtask

  // Reference model: remembers the last two issued instructions and a
  // count of cycles until HI/LO becomes valid.
  rec_t h1, h2;
  int   busy_left;

  function automatic logic model_stall(in_t x);
    logic lu, j, hh;
    lu = h1.w && h1.ld && ((x.ua && x.ra == h1.dst) || (x.ub && x.rb == h1.dst));
    j  = x.jr && ((h1.w && h1.ld && h1.dst == x.ra) || (h2.w && h2.dst == x.ra));
    hh = (busy_left > 0) && (x.hl || x.ms);
    return x.valid && !x.fl && (lu || j || hh);
  endfunction

  task automatic model_step(in_t x, logic st);
    rec_t n;
    if (x.fl) begin
      h1 = '{w: 1'b0, dst: 5'd0, ld: 1'b0};
      h2 = h1;
      busy_left = 0;
    end else begin
      n.w = x.valid && x.rw && (x.wr != 5'd0) && !st;
      n.dst = x.wr;
      n.ld = x.mr;
      h2 = h1;
      h1 = n;
      if (busy_left > 0) busy_left--;
      else if (x.valid && x.ms && !st) busy_left = x.md ? 33 : 2;
    end
  endtask

  initial begin
    int stalls, busys, dones, done_at;
    in_t x;

    do_reset();

    // Directed vectors, applied back to back from reset.
    add_vec(lw(5'd3, 5'd1),                 0, 0, 0);
    add_vec(alu(5'd4, 5'd3, 5'd5),          1, 0, 0);
    add_vec(alu(5'd4, 5'd3, 5'd5),          0, 0, 0);
    add_vec(lw(5'd7, 5'd1),                 0, 0, 0);
    add_vec(jr(5'd7),                       1, 0, 0);
    add_vec(jr(5'd7),                       1, 0, 0);
    add_vec(jr(5'd7),                       0, 0, 0);
    add_vec(alu(5'd9, 5'd1, 5'd2),          0, 0, 0);
    add_vec(jr(5'd9),                       0, 0, 0);
    add_vec(alu(5'd9, 5'd1, 5'd2),          0, 0, 0);
    add_vec(nop(),                          0, 0, 0);
    add_vec(jr(5'd9),                       1, 0, 0);
    add_vec(jr(5'd9),                       0, 0, 0);
    add_vec(lw(5'd0, 5'd1),                 0, 0, 0);
    add_vec(alu(5'd4, 5'd0, 5'd0),          0, 0, 0);
    add_vec(muldiv(1'b0),                   0, 0, 0);
    add_vec(mfhi(5'd8),                     1, 1, 0);
    add_vec(mfhi(5'd8),                     1, 1, 1);
    add_vec(mfhi(5'd8),                     0, 0, 0);
    add_vec(muldiv(1'b0),                   0, 0, 0);
    add_vec(lw(5'd3, 5'd1),                 0, 1, 0);
    add_vec(mthi(5'd3),                     1, 1, 1);
    add_vec(mthi(5'd3),                     0, 0, 0);
    add_vec(muldiv(1'b0),                   0, 0, 0);
    add_vec(muldiv(1'b0),                   1, 1, 0);
    add_vec(muldiv(1'b0),                   1, 1, 1);
    add_vec(muldiv(1'b0),                   0, 0, 0);
    add_vec(nop(),                          0, 1, 0);
    add_vec(nop(),                          0, 1, 1);
    add_vec(nop(),                          0, 0, 0);
    add_vec(lw(5'd5, 5'd1),                 0, 0, 0);
    add_vec(with_flush(alu(5'd6, 5'd5, 5'd5)), 0, 0, 0);
    add_vec(alu(5'd6, 5'd5, 5'd5),          0, 0, 0);

    foreach (tbl[k]) begin
      apply(tbl[k].i);
      #4;
      chk_outs($sformatf("vec%0d", k), tbl[k].st, tbl[k].bz, tbl[k].dn);
      next_cycle();
    end

    // div followed by mfhi: stall, busy and done across the whole operation.
    do_reset();
    apply(muldiv(1'b1));
    next_cycle();
    stalls = 0; busys = 0; dones = 0; done_at = -1;
    for (int c = 0; c < 60; c++) begin
      apply(mfhi(5'd8));
      #4;
      if (muldiv_busy) busys++;
      if (muldiv_done) begin dones++; done_at = c; end
      if (!stall_pc) break;
      stalls++;
      next_cycle();
    end
    next_cycle();
    chk("div.stall_cycles", stalls, 33);
    chk("div.busy_cycles", busys, 33);
    chk("div.done_pulses", dones, 1);
    chk("div.done_cycle", done_at, 32);

    // Flush in the middle of a div, with a load in EX.
    do_reset();
    apply(muldiv(1'b1));
    next_cycle();
    for (int c = 0; c < 21; c++) begin
      apply(nop());
      next_cycle();
    end
    apply(lw(5'd3, 5'd1));
    next_cycle();
    apply(with_flush(alu(5'd4, 5'd3, 5'd3)));
    #4;
    chk_outs("flush_cycle", 1'b0, 1'b1, 1'b0);
    next_cycle();
    apply(jr(5'd3));
    #4;
    chk_outs("after_flush", 1'b0, 1'b0, 1'b0);
    next_cycle();
    busys = 0; dones = 0;
    for (int c = 0; c < 40; c++) begin
      apply(mfhi(5'd8));
      #4;
      if (muldiv_busy) busys++;
      if (muldiv_done) dones++;
      next_cycle();
    end
    chk("flush.busy_after", busys, 0);
    chk("flush.done_after", dones, 0);

    // Asynchronous reset in the middle of a busy div.
    do_reset();
    apply(muldiv(1'b1));
    next_cycle();
    apply(mfhi(5'd8));
    #2;
    chk_outs("pre_async_rst", 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    chk_outs("async_rst", 1'b0, 1'b0, 1'b0);
    next_cycle();
    rst = 1'b0;

    // Randomized stimulus against the reference model.
    do_reset();
    h1 = '{w: 1'b0, dst: 5'd0, ld: 1'b0};
    h2 = h1;
    busy_left = 0;
    for (int c = 0; c < 800; c++) begin
      logic est;
      x = nop();
      x.valid = ($urandom_range(0, 9) != 0);
      x.ra = 5'($urandom_range(0, 3));
      x.rb = 5'($urandom_range(0, 3));
      x.wr = 5'($urandom_range(0, 3));
      x.ua = 1'($urandom_range(0, 1));
      x.ub = 1'($urandom_range(0, 1));
      x.rw = 1'($urandom_range(0, 1));
      x.mr = ($urandom_range(0, 2) == 0);
      x.jr = ($urandom_range(0, 6) == 0);
      x.ms = ($urandom_range(0, 9) == 0);
      x.md = ($urandom_range(0, 3) == 0);
      x.hl = ($urandom_range(0, 4) == 0);
      x.fl = ($urandom_range(0, 39) == 0);
      est = model_stall(x);
      apply(x);
      #4;
      chk_outs($sformatf("rand%0d", c), est, busy_left > 0, busy_left == 1);
      next_cycle();
      model_step(x, est);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
